// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline hazard sources in, per-stage stall/flush strobes out.
// Strobes are combinational from the sources; there is no backpressure on this bundle.
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_WIDTH = 5
);
   logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
   logic                      id_rs1_used;
   logic                      id_rs2_used;
   logic                      id_fence;
   logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
   logic                      ex_mem_read;
   logic                      ex_redirect;
   logic                      ex_div_start;
   logic                      div_done;
   logic                      mem_req;
   logic                      dmem_ready;
   logic                      trap;
   logic                      pc_stall;
   logic                      ifid_stall;
   logic                      idex_stall;
   logic                      exmem_stall;
   logic                      ifid_flush;
   logic                      idex_flush;
   logic                      exmem_flush;
   logic                      memwb_flush;
   logic                      fence_done;
   logic                      busy;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_fence,
             ex_rd_addr, ex_mem_read, ex_redirect, ex_div_start, div_done,
             mem_req, dmem_ready, trap,
      input  pc_stall, ifid_stall, idex_stall, exmem_stall,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, fence_done, busy
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_fence,
             ex_rd_addr, ex_mem_read, ex_redirect, ex_div_start, div_done,
             mem_req, dmem_ready, trap,
      output pc_stall, ifid_stall, idex_stall, exmem_stall,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, fence_done, busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/control unit: zero-cycle stall/flush strobes decoded from registered state + inputs.
// Priority: trap > memory wait > divide wait > fence drain > redirect > load-use > divide issue > fence issue.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH     = 5,
   parameter int FENCE_DRAIN_CYCLES = 3
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int CNT_W = $clog2(FENCE_DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, DIV_WAIT, FENCE_DRAIN} state_t;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic                      div_pend, div_pend_nxt;
   logic [REG_ADDR_WIDTH-1:0] rd;
   logic                      mem_wait;
   logic                      load_use;
   logic                      div_ret;
   logic                      cnt_last;

   assign rd       = hz.ex_rd_addr;
   assign mem_wait = hz.mem_req & ~hz.dmem_ready;
   assign load_use = hz.ex_mem_read & (rd != '0) &
                     ((hz.id_rs1_used & (hz.id_rs1_addr == rd)) |
                      (hz.id_rs2_used & (hz.id_rs2_addr == rd)));
   assign div_ret  = hz.div_done | div_pend;
   assign cnt_last = (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         cnt      <= '0;
         div_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         div_pend <= div_pend_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      div_pend_nxt = div_pend;
      if (hz.trap) begin
         state_nxt    = RUN;
         cnt_nxt      = '0;
         div_pend_nxt = 1'b0;
      end else if (mem_wait) begin
         // Completion seen while memory holds the pipe is remembered for the exit cycle.
         if (state == DIV_WAIT && hz.div_done) div_pend_nxt = 1'b1;
      end else begin
         case (state)
            DIV_WAIT: begin
               if (div_ret) begin
                  state_nxt    = RUN;
                  div_pend_nxt = 1'b0;
               end
            end
            FENCE_DRAIN: begin
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt_last) state_nxt = RUN;
            end
            default: begin
               if (hz.ex_redirect || load_use) begin
                  state_nxt = RUN;
               end else if (hz.ex_div_start) begin
                  state_nxt = DIV_WAIT;
               end else if (hz.id_fence) begin
                  state_nxt = FENCE_DRAIN;
                  cnt_nxt   = CNT_W'(FENCE_DRAIN_CYCLES);
               end
            end
         endcase
      end
   end

   always_comb begin
      hz.pc_stall    = 1'b0;
      hz.ifid_stall  = 1'b0;
      hz.idex_stall  = 1'b0;
      hz.exmem_stall = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_flush = 1'b0;
      hz.memwb_flush = 1'b0;
      hz.fence_done  = 1'b0;
      hz.busy        = 1'b0;
      if (rst_n) begin
         hz.busy = (state != RUN);
         if (hz.trap) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
         end else if (mem_wait) begin
            hz.pc_stall    = 1'b1;
            hz.ifid_stall  = 1'b1;
            hz.idex_stall  = 1'b1;
            hz.exmem_stall = 1'b1;
            hz.memwb_flush = 1'b1;
         end else if (state == DIV_WAIT) begin
            if (!div_ret) begin
               hz.pc_stall    = 1'b1;
               hz.ifid_stall  = 1'b1;
               hz.idex_stall  = 1'b1;
               hz.exmem_flush = 1'b1;
            end
         end else if (state == FENCE_DRAIN) begin
            hz.pc_stall   = 1'b1;
            hz.ifid_stall = 1'b1;
            hz.idex_flush = 1'b1;
            hz.fence_done = cnt_last;
         end else if (hz.ex_redirect) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
         end else if (load_use) begin
            hz.pc_stall   = 1'b1;
            hz.ifid_stall = 1'b1;
            hz.idex_flush = 1'b1;
         end else if (!hz.ex_div_start && hz.id_fence) begin
            hz.pc_stall   = 1'b1;
            hz.ifid_stall = 1'b1;
            hz.idex_flush = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected strobe vectors for each scenario.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) hz ();

   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .FENCE_DRAIN_CYCLES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   // Output vector order: pc ifid_s idex_s exmem_s | ifid_f idex_f exmem_f memwb_f | fence_done busy
   localparam logic [9:0] PC  = 10'b10_0000_0000;
   localparam logic [9:0] IFS = 10'b01_0000_0000;
   localparam logic [9:0] IDS = 10'b00_1000_0000;
   localparam logic [9:0] EXS = 10'b00_0100_0000;
   localparam logic [9:0] IFF = 10'b00_0010_0000;
   localparam logic [9:0] IDF = 10'b00_0001_0000;
   localparam logic [9:0] EXF = 10'b00_0000_1000;
   localparam logic [9:0] MWF = 10'b00_0000_0100;
   localparam logic [9:0] FD  = 10'b00_0000_0010;
   localparam logic [9:0] BSY = 10'b00_0000_0001;
   localparam logic [9:0] NIL = 10'b00_0000_0000;

   localparam logic [9:0] LU   = PC | IFS | IDF;
   localparam logic [9:0] DIVW = PC | IFS | IDS | EXF | BSY;
   localparam logic [9:0] MEMW = PC | IFS | IDS | EXS | MWF;
   localparam logic [9:0] TRP  = IFF | IDF | EXF;

   logic [9:0] obs;
   assign obs = {hz.pc_stall, hz.ifid_stall, hz.idex_stall, hz.exmem_stall,
                 hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush,
                 hz.fence_done, hz.busy};

   task automatic idle();
      hz.id_rs1_addr  = '0;
      hz.id_rs2_addr  = '0;
      hz.id_rs1_used  = 1'b0;
      hz.id_rs2_used  = 1'b0;
      hz.id_fence     = 1'b0;
      hz.ex_rd_addr   = '0;
      hz.ex_mem_read  = 1'b0;
      hz.ex_redirect  = 1'b0;
      hz.ex_div_start = 1'b0;
      hz.div_done     = 1'b0;
      hz.mem_req      = 1'b0;
      hz.dmem_ready   = 1'b1;
      hz.trap         = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n           = 1'b0;
      hz.trap         = 1'b1;
      hz.mem_req      = 1'b1;
      hz.dmem_ready   = 1'b0;
      hz.id_fence     = 1'b1;
      hz.ex_mem_read  = 1'b1;
      hz.ex_rd_addr   = 5'd3;
      hz.id_rs1_addr  = 5'd3;
      hz.id_rs1_used  = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs !== NIL) begin
         $display("FAIL reset_outputs: got %b want %b", obs, NIL);
         n_fail++;
      end
      next_cycle();
      idle();
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs !== NIL) begin
         $display("FAIL reset_release: got %b want %b", obs, NIL);
         n_fail++;
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      logic [9:0] exp [0:5];
      exp = '{LU, NIL, NIL, LU, NIL, NIL};
      for (int c = 0; c < 6; c++) begin
         idle();
         case (c)
            0: begin hz.ex_mem_read = 1; hz.ex_rd_addr = 5; hz.id_rs1_addr = 5; hz.id_rs1_used = 1; end
            2: begin hz.ex_mem_read = 1; hz.ex_rd_addr = 0; hz.id_rs1_addr = 0; hz.id_rs1_used = 1;
                     hz.id_rs2_addr = 0; hz.id_rs2_used = 1; end
            3: begin hz.ex_mem_read = 1; hz.ex_rd_addr = 7; hz.id_rs1_addr = 2; hz.id_rs1_used = 1;
                     hz.id_rs2_addr = 7; hz.id_rs2_used = 1; end
            4: begin hz.ex_mem_read = 1; hz.ex_rd_addr = 7; hz.id_rs2_addr = 7; hz.id_rs2_used = 0; end
            5: begin hz.ex_mem_read = 0; hz.ex_rd_addr = 9; hz.id_rs1_addr = 9; hz.id_rs1_used = 1; end
            default: ;
         endcase
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL load_use[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect();
      logic [9:0] exp [0:1];
      exp = '{IFF | IDF, NIL};
      for (int c = 0; c < 2; c++) begin
         idle();
         if (c == 0) begin
            hz.ex_redirect = 1; hz.ex_mem_read = 1; hz.ex_rd_addr = 4;
            hz.id_rs1_addr = 4; hz.id_rs1_used = 1;
         end
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL redirect[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_divide();
      logic [9:0] exp [0:6];
      exp = '{NIL, DIVW, DIVW, DIVW, DIVW, BSY, NIL};
      for (int c = 0; c < 7; c++) begin
         idle();
         case (c)
            0: begin hz.ex_div_start = 1; hz.id_fence = 1; end
            2: begin hz.ex_redirect = 1; hz.ex_div_start = 1; end
            5: hz.div_done = 1;
            default: ;
         endcase
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL divide[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_divide_mem_wait();
      logic [9:0] exp [0:4];
      exp = '{NIL, MEMW | BSY, MEMW | BSY, BSY, NIL};
      for (int c = 0; c < 5; c++) begin
         idle();
         case (c)
            0: hz.ex_div_start = 1;
            1: begin hz.mem_req = 1; hz.dmem_ready = 0; hz.div_done = 1; end
            2: begin hz.mem_req = 1; hz.dmem_ready = 0; end
            3: begin hz.mem_req = 1; hz.dmem_ready = 1; end
            default: ;
         endcase
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL div_mem_wait[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_fence();
      logic [9:0] exp [0:4];
      exp = '{LU, LU | BSY, LU | BSY, LU | FD | BSY, NIL};
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) hz.id_fence = 1;
         if (c == 2) hz.ex_redirect = 1;
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL fence[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_fence_mem_wait();
      logic [9:0] exp [0:6];
      exp = '{LU, LU | BSY, MEMW | BSY, MEMW | BSY, LU | BSY, LU | FD | BSY, NIL};
      for (int c = 0; c < 7; c++) begin
         idle();
         if (c == 0) hz.id_fence = 1;
         if (c == 2 || c == 3) begin hz.mem_req = 1; hz.dmem_ready = 0; end
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL fence_mem_wait[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_trap();
      logic [9:0] exp [0:8];
      exp = '{NIL, DIVW, TRP | BSY, NIL, LU, LU | BSY, LU | BSY, TRP | BSY, NIL};
      for (int c = 0; c < 9; c++) begin
         idle();
         case (c)
            0: hz.ex_div_start = 1;
            2: hz.trap = 1;
            4: hz.id_fence = 1;
            7: hz.trap = 1;
            default: ;
         endcase
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL trap[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_fence();
      logic [9:0] exp [0:8];
      exp = '{LU, LU | BSY, NIL, NIL, LU, LU | BSY, LU | BSY, LU | FD | BSY, NIL};
      for (int c = 0; c < 9; c++) begin
         idle();
         if (c == 0 || c == 4) hz.id_fence = 1;
         if (c == 2) begin
            hz.id_fence = 1;
            #1 rst_n = 1'b0;
         end
         if (c == 3) rst_n = 1'b1;
         @(negedge clk);
         n_chk++;
         if (obs !== exp[c]) begin
            $display("FAIL reset_mid_fence[%0d]: got %b want %b", c, obs, exp[c]);
            n_fail++;
         end
         next_cycle();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_redirect();
      test_divide();
      test_divide_mem_wait();
      test_fence();
      test_fence_mem_wait();
      test_trap();
      test_reset_mid_fence();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
